// File: rtl/aes_inv_cipher_sequencer.sv
// AES decryption round sequencer: drives op-select, state write and round-key index.
// Optional macro AES_SEQ_ABORT_EN: run low between LOAD and FARK aborts to IDLE.
module aes_inv_cipher_sequencer #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       run,
    input  logic       key_done,
    output logic       key_start,
    output logic [2:0] op_sel,
    output logic       state_we,
    output logic [3:0] round_key_idx,
    output logic       busy,
    output logic       ready
);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_KEYWAIT, S_ARK0, S_ISR, S_ISB,
        S_ARK, S_IMC, S_FISR, S_FISB, S_FARK, S_DONE
    } state_t;

    localparam logic [3:0] NR = 4'(NUM_ROUNDS);
    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_LOAD = 3'd1;
    localparam logic [2:0] OP_ISR  = 3'd2;
    localparam logic [2:0] OP_ISB  = 3'd3;
    localparam logic [2:0] OP_ARK  = 3'd4;
    localparam logic [2:0] OP_IMC  = 3'd5;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] op_sel_q, op_sel_d;
    logic       state_we_q, state_we_d;
    logic       key_start_q, key_start_d;
    logic [3:0] idx_q, idx_d;
    logic       busy_q, busy_d;
    logic       ready_q, ready_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE:    if (run) state_d = S_LOAD;
            S_LOAD:    state_d = S_KEYWAIT;
            S_KEYWAIT: if (key_done) state_d = S_ARK0;
            S_ARK0: begin
                state_d = S_ISR;
                cnt_d   = NR - 4'd1;
            end
            S_ISR:     state_d = S_ISB;
            S_ISB:     state_d = S_ARK;
            S_ARK:     state_d = S_IMC;
            S_IMC: begin
                if (cnt_q > 4'd1) begin
                    cnt_d   = cnt_q - 4'd1;
                    state_d = S_ISR;
                end else begin
                    state_d = S_FISR;
                end
            end
            S_FISR:    state_d = S_FISB;
            S_FISB:    state_d = S_FARK;
            S_FARK:    state_d = S_DONE;
            S_DONE:    if (!run) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
`ifdef AES_SEQ_ABORT_EN
        if (!run && state_q != S_IDLE && state_q != S_DONE) begin
            state_d = S_IDLE;
        end
`endif
        if (state_d == S_IDLE) cnt_d = NR;
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        op_sel_d    = OP_NOP;
        key_start_d = 1'b0;
        idx_d       = idx_q;
        unique case (state_d)
            S_LOAD: begin
                op_sel_d    = OP_LOAD;
                key_start_d = 1'b1;
            end
            S_ARK0: begin
                op_sel_d = OP_ARK;
                idx_d    = NR;
            end
            S_ARK: begin
                op_sel_d = OP_ARK;
                idx_d    = cnt_d;
            end
            S_FARK: begin
                op_sel_d = OP_ARK;
                idx_d    = 4'd0;
            end
            S_ISR, S_FISR: op_sel_d = OP_ISR;
            S_ISB, S_FISB: op_sel_d = OP_ISB;
            S_IMC:         op_sel_d = OP_IMC;
            default:       op_sel_d = OP_NOP;
        endcase
        state_we_d = (op_sel_d != OP_NOP);
        busy_d     = (state_d != S_IDLE) && (state_d != S_DONE);
        ready_d    = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= NR;
            op_sel_q    <= OP_NOP;
            state_we_q  <= 1'b0;
            key_start_q <= 1'b0;
            idx_q       <= 4'd0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_sel_q    <= op_sel_d;
            state_we_q  <= state_we_d;
            key_start_q <= key_start_d;
            idx_q       <= idx_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
        end
    end

    assign op_sel        = op_sel_q;
    assign state_we      = state_we_q;
    assign key_start     = key_start_q;
    assign round_key_idx = idx_q;
    assign busy          = busy_q;
    assign ready         = ready_q;

endmodule

// File: tb/tb_aes_inv_cipher_sequencer.sv
// Randomized bench for aes_inv_cipher_sequencer against a cycle-list reference model.
// Honours AES_SEQ_ABORT_EN to pick the abort or run-ignored expectations.
module tb_aes_inv_cipher_sequencer;

    localparam int NR = 10;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       run = 1'b0;
    logic       key_done = 1'b0;
    logic       key_start;
    logic [2:0] op_sel;
    logic       state_we;
    logic [3:0] round_key_idx;
    logic       busy;
    logic       ready;

    int n_checks = 0;
    int n_fail = 0;

    aes_inv_cipher_sequencer #(.NUM_ROUNDS(NR)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .run(run),
        .key_done(key_done),
        .key_start(key_start),
        .op_sel(op_sel),
        .state_we(state_we),
        .round_key_idx(round_key_idx),
        .busy(busy),
        .ready(ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_op"}, int'(op_sel), 0);
        check({tag, "_we"}, int'(state_we), 0);
        check({tag, "_ks"}, int'(key_start), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_ready"}, int'(ready), 0);
    endtask

    // Reference: list of op codes per cycle from LOAD to FARK.
    task automatic build_ops(input int kw, output int ops[$]);
        ops = {};
        ops.push_back(1);
        repeat (kw) ops.push_back(0);
        ops.push_back(4);
        for (int r = NR - 1; r >= 1; r--) begin
            ops.push_back(2); ops.push_back(3);
            ops.push_back(4); ops.push_back(5);
        end
        ops.push_back(2); ops.push_back(3); ops.push_back(4);
    endtask

    // Called at a negedge with the DUT in IDLE.
    task automatic do_op(input int kw, input int hold);
        int ops[$];
        int idxs[$];
        int wcnt;
        int n;
        build_ops(kw, ops);
        for (int r = NR; r >= 0; r--) idxs.push_back(r);
        n = ops.size();
        wcnt = 0;
        run = 1'b1;
        key_done = 1'($urandom);
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            check("op_sel", int'(op_sel), ops[c-1]);
            check("state_we", int'(state_we), int'(ops[c-1] != 0));
            check("key_start", int'(key_start), int'(c == 1));
            check("busy", int'(busy), 1);
            check("ready", int'(ready), 0);
            if (ops[c-1] == 4) check("ark_idx", int'(round_key_idx), idxs.pop_front());
            if (state_we) wcnt++;
            if (c >= 2 && c <= kw + 1) key_done = (c == kw + 1);
            else key_done = 1'($urandom);
`ifndef AES_SEQ_ABORT_EN
            run = 1'($urandom);
`endif
        end
        check("ark_count_left", idxs.size(), 0);
        check("we_count", wcnt, 4 * NR + 1);
        run = 1'b1;
        for (int h = 0; h <= hold; h++) begin
            @(negedge clk);
            check("done_ready", int'(ready), 1);
            check("done_busy", int'(busy), 0);
            check("done_op", int'(op_sel), 0);
            check("done_ks", int'(key_start), 0);
            key_done = 1'($urandom);
        end
        run = 1'b0;
        @(negedge clk);
        check_idle("idle_after");
    endtask

    initial begin
        reset_n = 1'b0;
        #12;
        check_idle("reset");
        check("reset_idx", int'(round_key_idx), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_idle("post_reset");

        do_op(1, 10);
        do_op(20, 2);
        for (int t = 0; t < 6; t++) begin
            do_op(int'($urandom_range(1, 25)), int'($urandom_range(0, 12)));
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                check_idle("gap");
            end
        end

        // Asynchronous reset while in IMC with counter 5 (key_done high).
        run = 1'b1;
        key_done = 1'b1;
        repeat (23) @(negedge clk);
        check("pre_reset_imc", int'(op_sel), 5);
        #2 reset_n = 1'b0;
        run = 1'b0;
        #1;
        check_idle("async_reset");
        check("async_reset_idx", int'(round_key_idx), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_idle("after_async");
        do_op(1, 0);

`ifdef AES_SEQ_ABORT_EN
        // Drop run during ISB of the round using key index 6.
        run = 1'b1;
        key_done = 1'b1;
        repeat (17) @(negedge clk);
        check("abort_pre_isb", int'(op_sel), 3);
        run = 1'b0;
        @(negedge clk);
        check_idle("abort");
        repeat (5) begin
            @(negedge clk);
            check("abort_no_ready", int'(ready), 0);
        end
        do_op(1, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
